// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the bundled address/control phase type
// used by the two-master arbiter.
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_e;

   localparam logic M_CPU = 1'b0;
   localparam logic M_DMA = 1'b1;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef struct packed {
      logic [31:0] haddr;
      logic [1:0]  htrans;
      logic        hwrite;
      logic [2:0]  hsize;
      logic [2:0]  hburst;
      logic [3:0]  hprot;
      logic        hmastlock;
   } ahb_addr_t;

endpackage

// File: rtl/ahblite_arb_fsm.sv
// Ownership state for the two-master arbiter: address/data-phase owner,
// data-phase valid flag and the anti-starvation hold counter.
module ahblite_arb_fsm
   import ahb_pkg::*;
#(
   parameter int unsigned M1_PRIORITY = 1,
   parameter int unsigned MAX_HOLD    = 8
) (
   input  logic       clk_i,
   input  logic       srst_i,
   input  logic       hready_i,
   input  logic [1:0] req_i,
   input  logic [1:0] owner_htrans_i,
   input  logic       owner_lock_i,
   output logic       addr_owner_o,
   output logic       data_owner_o,
   output logic       data_valid_o
);

   localparam logic       PRIO       = (M1_PRIORITY != 0);
   localparam logic       OTHER      = ~PRIO;
   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

   logic       addr_owner_q, addr_owner_d;
   logic       data_owner_q, data_owner_d;
   logic       data_valid_q, data_valid_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       next_owner;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         addr_owner_q <= M_CPU;
         data_owner_q <= M_CPU;
         data_valid_q <= 1'b0;
         hold_cnt_q   <= '0;
      end else begin
         addr_owner_q <= addr_owner_d;
         data_owner_q <= data_owner_d;
         data_valid_q <= data_valid_d;
         hold_cnt_q   <= hold_cnt_d;
      end
   end

   always_comb begin
      // Locked sequences and bursts in progress are never broken.
      next_owner = M_CPU;
      if (owner_lock_i || (owner_htrans_i == SEQ)) begin
         next_owner = addr_owner_q;
      end else if (req_i[0] ^ req_i[1]) begin
         next_owner = req_i[1];
      end else if (&req_i) begin
         next_owner = ((hold_cnt_q == HOLD_LIMIT) && (addr_owner_q == PRIO)) ? OTHER : PRIO;
      end

      addr_owner_d = addr_owner_q;
      data_owner_d = data_owner_q;
      data_valid_d = data_valid_q;
      hold_cnt_d   = hold_cnt_q;
      if (hready_i) begin
         data_valid_d = owner_htrans_i[1];
         data_owner_d = addr_owner_q;
         addr_owner_d = next_owner;
         if (req_i[OTHER] && (next_owner == PRIO)) begin
            hold_cnt_d = (hold_cnt_q == HOLD_LIMIT) ? hold_cnt_q : hold_cnt_q + 8'd1;
         end else begin
            hold_cnt_d = '0;
         end
      end
   end

   always_comb begin
      addr_owner_o = addr_owner_q;
      data_owner_o = data_owner_q;
      data_valid_o = data_valid_q;
   end

endmodule

// File: rtl/ahblite_bus_arbiter.sv
// Two-master AHB-Lite arbiter (CPU default master, DMA priority master):
// muxes the owner's address/control and write data, routes responses back.
module ahblite_bus_arbiter
   import ahb_pkg::*;
#(
   parameter int unsigned M1_PRIORITY = 1,
   parameter int unsigned MAX_HOLD    = 8
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] M0_HADDR,
   input  logic [1:0]  M0_HTRANS,
   input  logic        M0_HWRITE,
   input  logic [2:0]  M0_HSIZE,
   input  logic [2:0]  M0_HBURST,
   input  logic [3:0]  M0_HPROT,
   input  logic        M0_HMASTLOCK,
   input  logic [31:0] M0_HWDATA,
   output logic [31:0] M0_HRDATA,
   output logic        M0_HREADY,
   output logic        M0_HRESP,
   input  logic [31:0] M1_HADDR,
   input  logic [1:0]  M1_HTRANS,
   input  logic        M1_HWRITE,
   input  logic [2:0]  M1_HSIZE,
   input  logic [2:0]  M1_HBURST,
   input  logic [3:0]  M1_HPROT,
   input  logic        M1_HMASTLOCK,
   input  logic [31:0] M1_HWDATA,
   output logic [31:0] M1_HRDATA,
   output logic        M1_HREADY,
   output logic        M1_HRESP,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic        HMASTER
);

   ahb_addr_t  m0_a, m1_a, bus_a;
   logic       addr_owner, data_owner, data_valid;
   logic [1:0] route_rdy, route_rsp;

   ahblite_arb_fsm #(
      .M1_PRIORITY (M1_PRIORITY),
      .MAX_HOLD    (MAX_HOLD)
   ) u_fsm (
      .clk_i          (HCLK),
      .srst_i         (HRESET),
      .hready_i       (HREADY),
      .req_i          ({M1_HTRANS[1], M0_HTRANS[1]}),
      .owner_htrans_i (bus_a.htrans),
      .owner_lock_i   (bus_a.hmastlock),
      .addr_owner_o   (addr_owner),
      .data_owner_o   (data_owner),
      .data_valid_o   (data_valid)
   );

   assign m0_a  = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HPROT, M0_HMASTLOCK};
   assign m1_a  = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HPROT, M1_HMASTLOCK};
   assign bus_a = (addr_owner == M_DMA) ? m1_a : m0_a;

   assign HADDR     = bus_a.haddr;
   assign HTRANS    = bus_a.htrans;
   assign HWRITE    = bus_a.hwrite;
   assign HSIZE     = bus_a.hsize;
   assign HBURST    = bus_a.hburst;
   assign HPROT     = bus_a.hprot;
   assign HMASTLOCK = bus_a.hmastlock;
   assign HWDATA    = (data_owner == M_DMA) ? M1_HWDATA : M0_HWDATA;
   assign HMASTER   = addr_owner;

   // A master sees HREADY only while it owns a phase; everyone else stalls.
   for (genvar gi = 0; gi < 2; gi++) begin : g_route
      assign route_rdy[gi] = (addr_owner == 1'(gi)) || (data_valid && (data_owner == 1'(gi)));
      assign route_rsp[gi] = data_valid && (data_owner == 1'(gi));
   end

   assign M0_HREADY = HREADY & route_rdy[0];
   assign M1_HREADY = HREADY & route_rdy[1];
   assign M0_HRESP  = HRESP & route_rsp[0];
   assign M1_HRESP  = HRESP & route_rsp[1];
   assign M0_HRDATA = HRDATA;
   assign M1_HRDATA = HRDATA;

endmodule

// File: tb/tb_ahblite_bus_arbiter.sv
// Scoreboard bench for ahblite_bus_arbiter: directed scenarios plus random
// traffic, each cycle checked against a grant-rule reference model.
module tb_ahblite_bus_arbiter;

   localparam bit PRIO     = 1'b1;
   localparam int MAX_HOLD = 8;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, HRDATA;
   logic [1:0]  M0_HTRANS, M1_HTRANS;
   logic        M0_HWRITE, M1_HWRITE, M0_HMASTLOCK, M1_HMASTLOCK;
   logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
   logic [3:0]  M0_HPROT, M1_HPROT;
   logic        HREADY, HRESP;
   logic [31:0] M0_HRDATA, M1_HRDATA, HADDR, HWDATA;
   logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
   logic [1:0]  HTRANS;
   logic        HWRITE, HMASTLOCK, HMASTER;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;

   ahblite_bus_arbiter #(.M1_PRIORITY(1), .MAX_HOLD(MAX_HOLD)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
      .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
      .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
      .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
      .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
      .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
      .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HMASTER(HMASTER)
   );

   always #5 HCLK = ~HCLK;

   typedef struct packed {
      logic [31:0] id;
      logic        hmaster;
      logic [45:0] actl;
      logic [31:0] hwdata;
      logic        m0_rdy, m1_rdy, m0_rsp, m1_rsp;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc_no  = 0;
   bit   drv_done = 1'b0;

   // Reference model: who owns each phase and how long the DMA has been
   // winning against a waiting CPU.
   bit m_aown = 1'b0, m_down = 1'b0, m_dval = 1'b0;
   int m_streak = 0;

   function automatic bit pick(bit r0, bit r1, bit keep, bit own, int streak);
      if (keep) return own;
      if (r0 && !r1) return 1'b0;
      if (r1 && !r0) return 1'b1;
      if (r0 && r1) begin
         if (streak >= MAX_HOLD && own == PRIO) return !PRIO;
         return PRIO;
      end
      return 1'b0;
   endfunction

   function automatic void model_step();
      bit         r0 = M0_HTRANS[1];
      bit         r1 = M1_HTRANS[1];
      logic [1:0] own_tr = m_aown ? M1_HTRANS : M0_HTRANS;
      bit         own_lk = m_aown ? M1_HMASTLOCK : M0_HMASTLOCK;
      bit         other_req = PRIO ? r0 : r1;
      bit         g;
      if (HRESET) begin
         m_aown = 1'b0; m_down = 1'b0; m_dval = 1'b0; m_streak = 0;
         return;
      end
      if (!HREADY) return;
      g = pick(r0, r1, own_lk || (own_tr == 2'b11), m_aown, m_streak);
      m_dval = own_tr[1];
      m_down = m_aown;
      if (other_req && g == PRIO) m_streak = (m_streak + 1 > MAX_HOLD) ? MAX_HOLD : m_streak + 1;
      else m_streak = 0;
      m_aown = g;
   endfunction

   function automatic exp_t expect_now();
      exp_t e;
      e.id      = cyc_no;
      e.hmaster = m_aown;
      e.actl    = m_aown ? {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HPROT, M1_HMASTLOCK}
                         : {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HPROT, M0_HMASTLOCK};
      e.hwdata  = m_down ? M1_HWDATA : M0_HWDATA;
      e.m0_rdy  = HREADY && (m_aown == 1'b0 || (m_dval && m_down == 1'b0));
      e.m1_rdy  = HREADY && (m_aown == 1'b1 || (m_dval && m_down == 1'b1));
      e.m0_rsp  = HRESP && m_dval && m_down == 1'b0;
      e.m1_rsp  = HRESP && m_dval && m_down == 1'b1;
      e.rdata   = HRDATA;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp, input int id);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, id, act, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      model_step();
      #1;
   endtask

   task automatic issue();
      cyc_no++;
      exp_q.push_back(expect_now());
      step();
   endtask

   task automatic cyc(input logic [1:0] t0, input logic [1:0] t1, input logic lk0, input logic lk1,
                      input logic rdy, input logic rsp);
      M0_HTRANS = t0; M1_HTRANS = t1; M0_HMASTLOCK = lk0; M1_HMASTLOCK = lk1;
      HREADY = rdy; HRESP = rsp;
      M0_HWDATA = $urandom; M1_HWDATA = $urandom;
      issue();
   endtask

   // Monitor: one comparison set per presented cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge HCLK);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("hmaster", 64'(HMASTER), 64'(e.hmaster), e.id);
            chk("addr_ctl", 64'({HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK}), 64'(e.actl), e.id);
            chk("hwdata", 64'(HWDATA), 64'(e.hwdata), e.id);
            chk("m0_hready", 64'(M0_HREADY), 64'(e.m0_rdy), e.id);
            chk("m1_hready", 64'(M1_HREADY), 64'(e.m1_rdy), e.id);
            chk("m0_hresp", 64'(M0_HRESP), 64'(e.m0_rsp), e.id);
            chk("m1_hresp", 64'(M1_HRESP), 64'(e.m1_rsp), e.id);
            chk("hrdata", 64'({M0_HRDATA, M1_HRDATA}), 64'({e.rdata, e.rdata}), e.id);
            $display("[TB] cyc %0d HMASTER=%0d HADDR=%h HTRANS=%0d M0_RDY=%0d M1_RDY=%0d M0_RSP=%0d M1_RSP=%0d",
                     e.id, HMASTER, HADDR, HTRANS, M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
      M0_HADDR = '0; M0_HTRANS = 2'b00; M0_HWRITE = 1'b0; M0_HSIZE = 3'd2; M0_HBURST = 3'd0;
      M0_HPROT = 4'h3; M0_HMASTLOCK = 1'b0; M0_HWDATA = '0;
      M1_HADDR = '0; M1_HTRANS = 2'b00; M1_HWRITE = 1'b0; M1_HSIZE = 3'd2; M1_HBURST = 3'd0;
      M1_HPROT = 4'h1; M1_HMASTLOCK = 1'b0; M1_HWDATA = '0;
      step();
      cyc(2'b00, 2'b00, 0, 0, 1, 0);               // reset state
      HRESET = 1'b0;

      // CPU single read
      M0_HADDR = 32'h2000_0004; HRDATA = 32'hA5A5_A5A5;
      cyc(2'b10, 2'b00, 0, 0, 1, 0);
      cyc(2'b00, 2'b00, 0, 0, 1, 0);
      cyc(2'b00, 2'b00, 0, 0, 1, 0);

      // simultaneous requests, DMA wins, CPU holds its address
      M0_HADDR = 32'h2000_0040; M1_HADDR = 32'h2000_0080;
      cyc(2'b10, 2'b10, 0, 0, 1, 0);
      cyc(2'b10, 2'b10, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(2'b10, 2'b00, 0, 0, 1, 0);

      // DMA singles until the hold limit is about to expire, then an INCR4 burst
      for (int i = 0; i < MAX_HOLD - 1; i++) cyc(2'b10, 2'b10, 0, 0, 1, 0);
      M1_HADDR = 32'h2000_0100; M1_HBURST = 3'b011;
      cyc(2'b10, 2'b10, 0, 0, 1, 0);
      for (int i = 1; i < 4; i++) begin
         M1_HADDR = 32'h2000_0100 + 32'(4 * i);
         cyc(2'b10, 2'b11, 0, 0, 1, 0);
      end
      M1_HBURST = 3'b000;
      cyc(2'b10, 2'b00, 0, 0, 1, 0);
      cyc(2'b00, 2'b00, 0, 0, 1, 0);

      // continuous DMA singles against a waiting CPU
      for (int i = 0; i < 22; i++) cyc(2'b10, 2'b10, 0, 0, 1, 0);
      cyc(2'b00, 2'b00, 0, 0, 1, 0);

      // CPU locked sequence while DMA requests
      cyc(2'b10, 2'b00, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(2'b10, 2'b10, 1, 0, 1, 0);
      cyc(2'b10, 2'b10, 0, 0, 1, 0);
      cyc(2'b00, 2'b10, 0, 0, 1, 0);
      cyc(2'b00, 2'b00, 0, 0, 1, 0);

      // DMA write answered with a two-cycle ERROR
      M1_HADDR = 32'h4007_0000; M1_HWRITE = 1'b1;
      cyc(2'b00, 2'b10, 0, 0, 1, 0);
      cyc(2'b00, 2'b10, 0, 0, 1, 0);
      cyc(2'b00, 2'b00, 0, 0, 0, 1);
      cyc(2'b00, 2'b00, 0, 0, 1, 1);
      cyc(2'b00, 2'b00, 0, 0, 1, 0);

      // reset during a wait state abandons the transfer
      cyc(2'b00, 2'b10, 0, 0, 1, 0);
      cyc(2'b00, 2'b10, 0, 0, 1, 0);
      cyc(2'b10, 2'b00, 0, 0, 0, 0);
      HRESET = 1'b1;
      cyc(2'b10, 2'b00, 0, 0, 0, 0);
      HRESET = 1'b0;
      cyc(2'b00, 2'b00, 0, 0, 0, 0);
      cyc(2'b00, 2'b00, 0, 0, 1, 0);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         M0_HADDR = $urandom; M1_HADDR = $urandom;
         M0_HWRITE = 1'($urandom); M1_HWRITE = 1'($urandom);
         M0_HSIZE = 3'($urandom); M1_HSIZE = 3'($urandom);
         M0_HBURST = 3'($urandom); M1_HBURST = 3'($urandom);
         M0_HPROT = 4'($urandom); M1_HPROT = 4'($urandom);
         HRDATA = $urandom;
         HRESET = ($urandom_range(0, 99) == 0);
         cyc(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10,
             2'($urandom),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
      end
      HRESET = 1'b0;
      drv_done = 1'b1;
      @(negedge HCLK);
      @(negedge HCLK);
      chk("queue_drained", 64'(exp_q.size()), 64'd0, cyc_no);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
